// File: rtl/seq_match_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_match_fsm
// Brief    : Serial pattern matcher. W-bit symbols shift into a DEPTH-deep
//            history; once armed, each accepted symbol is compared together
//            with the held history against a run-time programmable pattern.
//            Registered one-cycle match pulse plus a saturating match counter.
// Options  : SEQ_MATCH_MASK_EN adds i_pat_mask, a per-entry don't-care bit.
// Revision : 1.0  initial release
// ============================================================================
module seq_match_fsm #(
  parameter int IN_W  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_in_valid,
  input  logic [IN_W-1:0]          i_in_sym,
  input  logic                     i_pat_load,
  input  logic [$clog2(DEPTH)-1:0] i_pat_idx,
  input  logic [IN_W-1:0]          i_pat_sym,
`ifdef SEQ_MATCH_MASK_EN
  input  logic                     i_pat_mask,
`endif
  input  logic                     i_cnt_clr,
  output logic                     o_match,
  output logic                     o_armed,
  output logic [CNT_W-1:0]         o_match_cnt
);

  localparam int FILL_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_next;
  logic [IN_W-1:0]   r_pat  [DEPTH];
  logic [IN_W-1:0]   r_hist [DEPTH];
  logic [IN_W-1:0]   w_cmp  [DEPTH];
`ifdef SEQ_MATCH_MASK_EN
  logic [DEPTH-1:0]  r_mask;
`endif
  logic              w_accept;
  logic              w_eq;
  logic              w_match_next;
  logic              r_match;
  logic              r_armed;
  logic [CNT_W-1:0]  r_cnt;

  // A pattern write always wins over a same-cycle symbol.
  assign w_accept = i_in_valid & ~i_pat_load;

  // Compare vector: the DEPTH-1 newest held symbols followed by the incoming one.
  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    if (k < DEPTH - 1) begin : g_hist
      assign w_cmp[k] = r_hist[k+1];
    end else begin : g_new
      assign w_cmp[k] = i_in_sym;
    end
  end

  // Whole-pattern equality; masked positions are don't-cares.
  always_comb begin
    w_eq = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
`ifdef SEQ_MATCH_MASK_EN
      if ((w_cmp[k] != r_pat[k]) && !r_mask[k]) w_eq = 1'b0;
`else
      if (w_cmp[k] != r_pat[k]) w_eq = 1'b0;
`endif
    end
  end

  // Next-state, fill count and match decision.
  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    w_match_next = 1'b0;
    if (i_pat_load) begin
      w_state_next = S_FILL;
      w_fill_next  = '0;
    end else if (i_in_valid) begin
      case (r_state)
        S_FILL: begin
          if (r_fill == FILL_W'(DEPTH - 2)) begin
            w_fill_next  = FILL_W'(DEPTH - 1);
            w_state_next = S_ARMED;
          end else begin
            w_fill_next = r_fill + 1'b1;
          end
        end
        S_ARMED: w_match_next = w_eq;
        default: w_state_next = S_FILL;
      endcase
    end
  end

  // State register with registered match pulse and armed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fill  <= w_fill_next;
      r_match <= w_match_next;
      r_armed <= (w_state_next == S_ARMED);
    end
  end

  // Pattern storage; an out-of-range index writes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_pat[k] <= '0;
`ifdef SEQ_MATCH_MASK_EN
      r_mask <= '0;
`endif
    end else if (i_pat_load) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k == int'(i_pat_idx)) begin
          r_pat[k] <= i_pat_sym;
`ifdef SEQ_MATCH_MASK_EN
          r_mask[k] <= i_pat_mask;
`endif
        end
      end
    end
  end

  // History shift register: oldest at 0, newest enters at DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < DEPTH - 1; k++) r_hist[k] <= r_hist[k+1];
      r_hist[DEPTH-1] <= i_in_sym;
    end
  end

  // Saturating match counter; clear beats a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match_next && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_match     = r_match;
  assign o_armed     = r_armed;
  assign o_match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_match_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_match_fsm
// Brief    : Scoreboard bench for seq_match_fsm. Two instances share stimulus:
//            CNT_W=8 (main) and CNT_W=2 (saturation). Expected outputs are
//            queued per driven edge and checked by an independent monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_match_fsm;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       pat_load;
  logic [1:0] pat_idx;
  logic [1:0] pat_sym;
  logic       cnt_clr;
`ifdef SEQ_MATCH_MASK_EN
  logic       pat_mask;
`endif
  logic       m_match, m_armed, s_match, s_armed;
  logic [7:0] m_cnt;
  logic [1:0] s_cnt;

  int total = 0;
  int bad   = 0;
  int stepno = 0;

  typedef struct {
    int id;
    int m;
    int a;
    int c;
    int s;   // saturating-instance count, -1 = not checked
  } exp_t;

  exp_t q[$];

  seq_match_fsm #(.IN_W(2), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_in_valid(in_valid), .i_in_sym(in_sym),
    .i_pat_load(pat_load), .i_pat_idx(pat_idx), .i_pat_sym(pat_sym),
`ifdef SEQ_MATCH_MASK_EN
    .i_pat_mask(pat_mask),
`endif
    .i_cnt_clr(cnt_clr), .o_match(m_match), .o_armed(m_armed), .o_match_cnt(m_cnt)
  );

  seq_match_fsm #(.IN_W(2), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i_in_valid(in_valid), .i_in_sym(in_sym),
    .i_pat_load(pat_load), .i_pat_idx(pat_idx), .i_pat_sym(pat_sym),
`ifdef SEQ_MATCH_MASK_EN
    .i_pat_mask(pat_mask),
`endif
    .i_cnt_clr(cnt_clr), .o_match(s_match), .o_armed(s_armed), .o_match_cnt(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int id, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, id, act, exp);
    end
  endtask

  // Monitor: checks every queued expectation just after the edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("match", e.id, int'(m_match), e.m);
        chk("armed", e.id, int'(m_armed), e.a);
        chk("cnt",   e.id, int'(m_cnt),   e.c);
        chk("sat_armed", e.id, int'(s_armed), e.a);
        if (e.s >= 0) chk("sat_cnt", e.id, int'(s_cnt), e.s);
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] s, input logic ld,
                      input logic [1:0] idx, input logic [1:0] ps, input logic clr,
                      input int em, input int ea, input int ec, input int es);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_sym = s; pat_load = ld; pat_idx = idx; pat_sym = ps; cnt_clr = clr;
    @(posedge clk);
    stepno++;
    e.id = stepno; e.m = em; e.a = ea; e.c = ec; e.s = es;
    q.push_back(e);
  endtask

  task automatic sym(input logic [1:0] s, input int em, input int ea, input int ec, input int es);
    step(1'b1, s, 1'b0, 2'd0, 2'd0, 1'b0, em, ea, ec, es);
  endtask

  task automatic load(input logic [1:0] idx, input logic [1:0] ps, input int ec, input int es);
    step(1'b0, 2'd0, 1'b1, idx, ps, 1'b0, 0, 0, ec, es);
  endtask

`ifdef SEQ_MATCH_MASK_EN
  task automatic mload(input logic [1:0] idx, input logic [1:0] ps, input logic mk,
                       input int ec, input int es);
    pat_mask = mk;
    load(idx, ps, ec, es);
    @(negedge clk);
    pat_mask = 1'b0;
    pat_load = 1'b0;
  endtask
`endif

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_match", stepno, int'(m_match), 0);
    chk("rst_armed", stepno, int'(m_armed), 0);
    chk("rst_cnt",   stepno, int'(m_cnt),   0);
    chk("rst_sat_cnt", stepno, int'(s_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", stepno);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sym = 2'd0; pat_load = 1'b0;
    pat_idx = 2'd0; pat_sym = 2'd0; cnt_clr = 1'b0;
`ifdef SEQ_MATCH_MASK_EN
    pat_mask = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("init_match", 0, int'(m_match), 0);
    chk("init_armed", 0, int'(m_armed), 0);
    chk("init_cnt",   0, int'(m_cnt),   0);
    rst = 1'b0;

    // Basic match: pattern 3,1,2,0
    load(2'd0, 2'd3, 0, 0); load(2'd1, 2'd1, 0, 0);
    load(2'd2, 2'd2, 0, 0); load(2'd3, 2'd0, 0, 0);
    sym(2'd3, 0, 0, 0, 0);
    sym(2'd1, 0, 0, 0, 0);
    sym(2'd2, 0, 1, 0, 0);
    sym(2'd0, 1, 1, 1, 1);
    // Reset while match=1 and armed=1
    async_reset();
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0);

    // Overlap: pattern 1,1,1,1, six ones
    load(2'd0, 2'd1, 0, 0); load(2'd1, 2'd1, 0, 0);
    load(2'd2, 2'd1, 0, 0); load(2'd3, 2'd1, 0, 0);
    sym(2'd1, 0, 0, 0, 0);
    sym(2'd1, 0, 0, 0, 0);
    sym(2'd1, 0, 1, 0, 0);
    sym(2'd1, 1, 1, 1, 1);
    sym(2'd1, 1, 1, 2, 2);
    sym(2'd1, 1, 1, 3, 3);
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0, 1, 3, 3);

    // Collision: load idx2=0 with a valid symbol 3; pattern becomes 1,1,0,1
    step(1'b1, 2'd3, 1'b1, 2'd2, 2'd0, 1'b0, 0, 0, 3, 3);
    sym(2'd0, 0, 0, 3, 3);
    sym(2'd1, 0, 0, 3, 3);   // would match if still armed
    sym(2'd1, 0, 1, 3, 3);
    sym(2'd1, 0, 1, 3, 3);
    sym(2'd0, 0, 1, 3, 3);
    sym(2'd1, 1, 1, 4, 3);   // saturated instance holds at 3
    // Clear alone leaves state alone
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 0, 1, 0, 0);

    // Saturation: pattern 0,0,0,0, ten zeros
    load(2'd0, 2'd0, 0, 0); load(2'd1, 2'd0, 0, 0);
    load(2'd2, 2'd0, 0, 0); load(2'd3, 2'd0, 0, 0);
    sym(2'd0, 0, 0, 0, 0);
    sym(2'd0, 0, 0, 0, 0);
    sym(2'd0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) sym(2'd0, 1, 1, i, (i > 3) ? 3 : i);
    // Clear plus matching symbol: pulse but count 0
    step(1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1, 1, 0, 0);
    sym(2'd0, 1, 1, 1, 1);
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 0, 1, 1, 1);

`ifdef SEQ_MATCH_MASK_EN
    // Mask: pattern 2,x,2,x
    mload(2'd0, 2'd2, 1'b0, 1, 1); mload(2'd1, 2'd0, 1'b1, 1, 1);
    mload(2'd2, 2'd2, 1'b0, 1, 1); mload(2'd3, 2'd0, 1'b1, 1, 1);
    sym(2'd2, 0, 0, 1, 1); sym(2'd0, 0, 0, 1, 1);
    sym(2'd2, 0, 1, 1, 1); sym(2'd3, 1, 1, 2, 2);
    mload(2'd0, 2'd2, 1'b0, 2, 2);
    sym(2'd2, 0, 0, 2, 2); sym(2'd3, 0, 0, 2, 2);
    sym(2'd2, 0, 1, 2, 2); sym(2'd1, 1, 1, 3, 3);
    mload(2'd0, 2'd2, 1'b0, 3, 3);
    sym(2'd2, 0, 0, 3, 3); sym(2'd0, 0, 0, 3, 3);
    sym(2'd1, 0, 1, 3, 3); sym(2'd3, 0, 1, 3, 3);
`endif

    @(negedge clk);
    in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", stepno, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_match_fsm.md
Name: seq_match_fsm

Overview:
- Parametrised successor to the team's small two-input registered FSM benchmark cells: a serial pattern-matching state machine with W-bit input symbols, a run-time programmable pattern of DEPTH symbols, registered match outputs and a saturating match counter.
- Sits in the sequential-benchmark library as a scalable test target.
- Width, depth and counter size are set by parameters rather than hand-expanded gates.

Parameters:
- IN_W, 2, input symbol width in bits (≥1).
- DEPTH, 4, pattern length in symbols (≥2).
- CNT_W, 8, match counter width in bits (≥1).

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_sym is presented this cycle.
- in_sym  input  IN_W  input symbol.
- pat_load  input  1  write one pattern entry this cycle.
- pat_idx  input  $clog2(DEPTH)  pattern entry index; 0 = oldest symbol position.
- pat_sym  input  IN_W  pattern entry value.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle match pulse.
- armed  output  1  high when state is ARMED.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (async, active-high) forces the following; rst deasserts synchronously into FILL:
  - all pattern entries = 0
  - history = 0
  - fill count = 0
  - state = FILL
  - match = 0
  - match_cnt = 0
  - armed = 0
- History is a DEPTH-deep shift register of accepted symbols; the newest symbol enters position DEPTH-1 and the oldest sits at position 0.
- An accepted symbol (in_valid=1, pat_load=0) shifts into history on the rising edge.
- Compare vector = {history[1..DEPTH-1], in_sym} versus pattern[0..DEPTH-1].
- States:
  - FILL: fewer than DEPTH-1 symbols held. Each accepted symbol increments the fill count. When a symbol is accepted with fill count = DEPTH-2, the fill count goes to DEPTH-1 and the state goes to ARMED.
  - ARMED: on each accepted symbol, match <= (compare vector equals pattern). Overlapping matches are detected; e.g. pattern 1,1,1,1 on input 1,1,1,1,1 gives two pulses.
- Latency:
  - match is high for exactly the one cycle after the edge that accepted the completing symbol.
  - match is 0 on any edge where no symbol is accepted.
  - match is never asserted while in FILL.
- Pattern write: when pat_load=1 on an edge:
  - pattern[pat_idx] <= pat_sym
  - fill count <= 0, state <= FILL, match <= 0
  - history is left unchanged but is not used until refilled.
  - A pat_idx value ≥ DEPTH is ignored for the write but still forces the return to FILL.
- Simultaneous pat_load and in_valid: the pattern write wins and the symbol is dropped.
- match_cnt:
  - Increments on each edge where match is being set to 1; saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0; cnt_clr has priority over a same-edge increment.
  - cnt_clr does not affect state, history or pattern.
- armed = (state == ARMED), registered.
- Reset asserted mid-stream returns immediately to the reset values; any partial match is discarded.

Optional Feature:
- Macro SEQ_MATCH_MASK_EN.
- When defined:
  - Adds input port pat_mask (1 bit), written into a per-entry mask bit alongside pat_sym on pat_load.
  - A position with mask=1 is a don't-care and always compares equal.
  - Reset value of all mask bits = 0.
- When undefined: the port is absent and all positions compare exactly.

Test Plan (IN_W=2, DEPTH=4, CNT_W=8 unless noted):
- Reset: assert rst asynchronously between edges -> match=0, armed=0 and match_cnt=0 immediately; after release, state is FILL.
- Basic match:
  - Stimulus: load pattern 3,1,2,0 (idx 0..3), then stream 3,1,2,0 with in_valid=1 back-to-back.
  - Required: armed rises after the 3rd symbol; match=1 only in the cycle after the 4th symbol; match_cnt=1.
- Overlap:
  - Stimulus: pattern 1,1,1,1; stream 1 ×6.
  - Required: match pulses on the cycles after symbols 4, 5 and 6; match_cnt=3.
- Write/stream collision:
  - Stimulus: while ARMED, assert pat_load (idx 2, sym 0) together with in_valid (sym 3).
  - Required: the symbol is dropped; armed=0 the next cycle; 3 more symbols are needed before a match is possible.
- Saturation and clear:
  - Stimulus: CNT_W=2, pattern 0,0,0,0; stream 0 ×10.
  - Required: match_cnt sticks at 3. Then cnt_clr together with a matching symbol gives match=1 and match_cnt=0.
- Mask (SEQ_MATCH_MASK_EN defined):
  - Stimulus: pattern 2,x,2,x with mask=1 at idx 1 and 3; stream 2,0,2,3 then 2,3,2,1.
  - Required: both sequences produce match; stream 2,0,1,3 does not.
